// File: rtl/shtp_pkg.sv
// Shared types and constants for the SHTP sensor-report parser.
// Field offsets are byte positions inside a report, where byte 0 is the report ID.
package shtp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RPT_ID,
        ST_RPT_BODY,
        ST_SKIP
    } state_t;

    typedef enum logic [1:0] {
        HDR_DONE,
        HDR_ERR,
        HDR_SKIP,
        HDR_RPT
    } hdr_dec_t;

    typedef enum logic [1:0] {
        RPT_TS,
        RPT_QUAT,
        RPT_GYRO
    } rpt_kind_t;

    localparam logic [15:0] SHTP_HDR_LEN = 16'd4;
    localparam logic [3:0]  RPT_LEN_QUAT = 4'd14;
    localparam logic [3:0]  RPT_LEN_GYRO = 4'd10;
    localparam logic [3:0]  RPT_LEN_TS   = 4'd5;

    localparam logic [7:0]  RPT_ID_BASE_TS   = 8'hFB;
    localparam logic [7:0]  RPT_ID_TS_REBASE = 8'hFA;

    localparam logic [3:0]  OFS_QUAT_I    = 4'd4;
    localparam logic [3:0]  OFS_QUAT_J    = 4'd6;
    localparam logic [3:0]  OFS_QUAT_K    = 4'd8;
    localparam logic [3:0]  OFS_QUAT_REAL = 4'd10;
    localparam logic [3:0]  OFS_GYRO_X    = 4'd4;
    localparam logic [3:0]  OFS_GYRO_Y    = 4'd6;
    localparam logic [3:0]  OFS_GYRO_Z    = 4'd8;

    // Both reports place their 16-bit words back to back from the same offset,
    // so one four-word staging array serves either report.
    localparam logic [3:0]  FIELD_FIRST = OFS_QUAT_I;
    localparam logic [3:0]  FIELD_LAST  = OFS_QUAT_REAL + 4'd1;

    function automatic logic is_field_byte(input logic [3:0] idx);
        return (idx >= FIELD_FIRST) && (idx <= FIELD_LAST);
    endfunction

endpackage

// File: rtl/shtp_header_decoder.sv
// Captures the SHTP header length/channel bytes and classifies the packet
// once the fourth (sequence) header byte arrives.
module shtp_header_decoder
    import shtp_pkg::*;
#(
    parameter logic [7:0]  SENSOR_CHANNEL = 8'd3,
    parameter logic [15:0] MAX_LEN        = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic [1:0]  cap_idx,
    input  logic [7:0]  cap_byte,
    output logic [15:0] eff_len,
    output logic [1:0]  decision
);

    logic [7:0] len_lsb_q;
    logic [6:0] len_msb_q;
    logic [7:0] chan_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_lsb_q <= '0;
            len_msb_q <= '0;
            chan_q    <= '0;
        end else if (cap_en) begin
            case (cap_idx)
                2'd0:    len_lsb_q <= cap_byte;
                2'd1:    len_msb_q <= cap_byte[6:0];
                2'd2:    chan_q    <= cap_byte;
                default: ;
            endcase
        end
    end

    // Bit 15 of the length field is the continuation flag and never counts.
    assign eff_len = {1'b0, len_msb_q, len_lsb_q};

    // NOTE: the combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        decision = HDR_RPT;
        if (eff_len <= SHTP_HDR_LEN)
            decision = HDR_DONE;
        else if (eff_len > MAX_LEN)
            decision = HDR_ERR;
        else if (chan_q != SENSOR_CHANNEL)
            decision = HDR_SKIP;
    end

endmodule

// File: rtl/shtp_report_parser.sv
// SHTP byte-stream parser: walks the reports of each sensor-channel packet and
// publishes rotation-vector and calibrated-gyro words with one-cycle valid pulses.
module shtp_report_parser
    import shtp_pkg::*;
#(
    parameter logic [7:0]  SENSOR_CHANNEL = 8'd3,
    parameter logic [7:0]  QUAT_ID        = 8'h05,
    parameter logic [7:0]  GYRO_ID        = 8'h02,
    parameter logic [15:0] MAX_LEN        = 16'd256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        pkt_end,
    output logic        quat_valid,
    output logic [15:0] quat_w,
    output logic [15:0] quat_x,
    output logic [15:0] quat_y,
    output logic [15:0] quat_z,
    output logic        gyro_valid,
    output logic [15:0] gyro_x,
    output logic [15:0] gyro_y,
    output logic [15:0] gyro_z,
    output logic        parse_err
);

    state_t          state_q, state_n, st_cur;
    rpt_kind_t       kind_q, kind_n;
    logic [15:0]     cnt_q, cnt_n, cnt_base;
    logic [3:0]      idx_q, idx_n;
    logic [3:0]      rlen_q, rlen_n;
    logic [3:0][15:0] stage_q, stage_n;
    logic [2:0]      rel;
    logic            byte_ok, hdr_cap_en;
    logic            err_n, fire_quat, fire_gyro;
    logic [15:0]     hdr_len;
    logic [1:0]      hdr_decision;

    // A pkt_start restarts the packet before any byte in the same cycle is used.
    assign st_cur     = pkt_start ? ST_HDR : state_q;
    assign cnt_base   = pkt_start ? 16'd0 : cnt_q;
    assign byte_ok    = rx_valid && (st_cur != ST_IDLE);
    assign hdr_cap_en = byte_ok && (st_cur == ST_HDR);

    shtp_header_decoder #(
        .SENSOR_CHANNEL (SENSOR_CHANNEL),
        .MAX_LEN        (MAX_LEN)
    ) u_hdr (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (hdr_cap_en),
        .cap_idx  (cnt_base[1:0]),
        .cap_byte (rx_byte),
        .eff_len  (hdr_len),
        .decision (hdr_decision)
    );

    always_comb begin
        state_n   = st_cur;
        cnt_n     = cnt_base;
        idx_n     = idx_q;
        rlen_n    = rlen_q;
        kind_n    = kind_q;
        stage_n   = stage_q;
        rel       = '0;
        fire_quat = 1'b0;
        fire_gyro = 1'b0;
        err_n     = pkt_start && (state_q != ST_IDLE);

        if (byte_ok) begin
            unique case (st_cur)
                ST_HDR: begin
                    if (cnt_base[1:0] == 2'd3) begin
                        unique case (hdr_dec_t'(hdr_decision))
                            HDR_DONE: state_n = ST_IDLE;
                            HDR_ERR: begin
                                err_n   = 1'b1;
                                state_n = ST_SKIP;
                            end
                            HDR_SKIP: state_n = ST_SKIP;
                            default:  state_n = ST_RPT_ID;
                        endcase
                    end
                end
                ST_RPT_ID: begin
                    idx_n   = 4'd1;
                    state_n = ST_RPT_BODY;
                    if (rx_byte == RPT_ID_BASE_TS || rx_byte == RPT_ID_TS_REBASE) begin
                        kind_n = RPT_TS;
                        rlen_n = RPT_LEN_TS;
                    end else if (rx_byte == QUAT_ID) begin
                        kind_n = RPT_QUAT;
                        rlen_n = RPT_LEN_QUAT;
                    end else if (rx_byte == GYRO_ID) begin
                        kind_n = RPT_GYRO;
                        rlen_n = RPT_LEN_GYRO;
                    end else begin
                        state_n = ST_SKIP;
                    end
                end
                ST_RPT_BODY: begin
                    if (is_field_byte(idx_q)) begin
                        rel = idx_q[2:0] - FIELD_FIRST[2:0];
                        if (rel[0])
                            stage_n[rel[2:1]][15:8] = rx_byte;
                        else
                            stage_n[rel[2:1]][7:0]  = rx_byte;
                    end
                    idx_n = idx_q + 4'd1;
                    if (idx_q == rlen_q - 4'd1) begin
                        fire_quat = (kind_q == RPT_QUAT);
                        fire_gyro = (kind_q == RPT_GYRO);
                        state_n   = ST_RPT_ID;
                    end
                end
                default: ;
            endcase

            cnt_n = cnt_base + 16'd1;
            if (st_cur != ST_HDR && cnt_n == hdr_len)
                state_n = ST_IDLE;
        end

        // The byte of this cycle is already accounted for; an end that arrives
        // short of the declared length is a truncation.
        if (pkt_end && state_n != ST_IDLE) begin
            err_n   = 1'b1;
            state_n = ST_IDLE;
        end
    end

    // NOTE: the staging array is a handful of flops, not a RAM, so it takes the
    // async reset like everything else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            kind_q     <= RPT_TS;
            cnt_q      <= '0;
            idx_q      <= '0;
            rlen_q     <= '0;
            stage_q    <= '0;
            quat_valid <= 1'b0;
            gyro_valid <= 1'b0;
            parse_err  <= 1'b0;
            quat_w     <= '0;
            quat_x     <= '0;
            quat_y     <= '0;
            quat_z     <= '0;
            gyro_x     <= '0;
            gyro_y     <= '0;
            gyro_z     <= '0;
        end else begin
            state_q    <= state_n;
            kind_q     <= kind_n;
            cnt_q      <= cnt_n;
            idx_q      <= idx_n;
            rlen_q     <= rlen_n;
            stage_q    <= stage_n;
            quat_valid <= fire_quat;
            gyro_valid <= fire_gyro;
            parse_err  <= err_n;
            // stage_n includes the current byte, which is the z MSB for gyro.
            if (fire_quat) begin
                quat_x <= stage_n[0];
                quat_y <= stage_n[1];
                quat_z <= stage_n[2];
                quat_w <= stage_n[3];
            end
            if (fire_gyro) begin
                gyro_x <= stage_n[0];
                gyro_y <= stage_n[1];
                gyro_z <= stage_n[2];
            end
        end
    end

endmodule

// File: tb/tb_shtp_report_parser.sv
// Scoreboard bench for shtp_report_parser: directed SHTP packets queue their
// expected pulses (with cycle stamps); a negedge monitor pops and compares.
module tb_shtp_report_parser;

    localparam int EV_NONE = 0;
    localparam int EV_QUAT = 1;
    localparam int EV_GYRO = 2;
    localparam int EV_ERR  = 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          at;
        int          kind;
        int          stamp;
        logic [63:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        pkt_end = 1'b0;
    logic        quat_valid, gyro_valid, parse_err;
    logic [15:0] quat_w, quat_x, quat_y, quat_z;
    logic [15:0] gyro_x, gyro_y, gyro_z;

    ev_t pend[$];
    ev_t sb[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_pass = 0;
    int  q_cyc = -1;
    int  g_cyc = -1;
    bq_t p;

    shtp_report_parser dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_start  (pkt_start),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .pkt_end    (pkt_end),
        .quat_valid (quat_valid),
        .quat_w     (quat_w),
        .quat_x     (quat_x),
        .quat_y     (quat_y),
        .quat_z     (quat_z),
        .gyro_valid (gyro_valid),
        .gyro_x     (gyro_x),
        .gyro_y     (gyro_y),
        .gyro_z     (gyro_z),
        .parse_err  (parse_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int at, input int kind, input logic [63:0] data);
        ev_t e;
        e.at = at; e.kind = kind; e.stamp = 0; e.data = data;
        pend.push_back(e);
    endtask

    // Pending events become scoreboard entries when their triggering cycle is driven.
    task automatic release_pend(input int at);
        ev_t e;
        while (pend.size() > 0 && pend[0].at == at) begin
            e = pend.pop_front();
            e.stamp = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input bq_t b, input bit do_end);
        release_pend(-1);
        pkt_start = 1'b1;
        tick();
        pkt_start = 1'b0;
        foreach (b[i]) begin
            release_pend(i);
            send_byte(b[i]);
        end
        if (do_end) begin
            release_pend(b.size());
            pkt_end = 1'b1;
            tick();
            pkt_end = 1'b0;
        end
        tick();
    endtask

    task automatic mon(input string nm, input int kind, input logic [63:0] data);
        ev_t e;
        e.kind = EV_NONE; e.stamp = -1; e.data = '0; e.at = 0;
        if (sb.size() > 0) e = sb.pop_front();
        if (kind == EV_QUAT) q_cyc = cyc;
        if (kind == EV_GYRO) g_cyc = cyc;
        check(nm, {32'(kind), 32'(cyc), data}, {32'(e.kind), 32'(e.stamp), e.data});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (quat_valid) mon("quat_pulse", EV_QUAT, {quat_x, quat_y, quat_z, quat_w});
            if (gyro_valid) mon("gyro_pulse", EV_GYRO, {gyro_x, gyro_y, gyro_z, 16'h0000});
            if (parse_err)  mon("err_pulse", EV_ERR, 64'h0);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_quat", {quat_x, quat_y, quat_z, quat_w}, '0);
        check("rst_gyro", {gyro_x, gyro_y, gyro_z}, '0);
        check("rst_flags", {quat_valid, gyro_valid, parse_err}, '0);
        rst = 1'b0;
        tick();

        // Timestamp base report then rotation vector, length 23.
        p = '{8'h17, 8'h00, 8'h03, 8'h00, 8'hFB, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h05, 8'h11, 8'h02, 8'h00, 8'h34, 8'h12, 8'h00, 8'hFF,
              8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00};
        expect_ev(22, EV_QUAT, {16'h1234, 16'hFF00, 16'h0001, 16'h4000});
        send_pkt(p, 1);

        // Gyro-only packet, length 14.
        p = '{8'h0E, 8'h00, 8'h03, 8'h01, 8'h02, 8'h22, 8'h03, 8'h00,
              8'h00, 8'h02, 8'h00, 8'hFE, 8'h00, 8'h00};
        expect_ev(13, EV_GYRO, {16'h0200, 16'hFE00, 16'h0000, 16'h0000});
        send_pkt(p, 1);

        // Quat then gyro in one packet, length 28.
        p = '{8'h1C, 8'h00, 8'h03, 8'h02,
              8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h80,
              8'hFF, 8'h7F, 8'h00, 8'hC0, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h34, 8'h12};
        expect_ev(17, EV_QUAT, {16'h0100, 16'h8000, 16'h7FFF, 16'hC000});
        expect_ev(27, EV_GYRO, {16'h0001, 16'hFFFF, 16'h1234, 16'h0000});
        send_pkt(p, 1);
        check("pulse_gap_ge_10", {q_cyc > 0, (g_cyc - q_cyc) >= 10}, 2'b11);

        // Quat packet truncated after 12 bytes: error, outputs untouched.
        p = '{8'h12, 8'h00, 8'h03, 8'h03, 8'h05, 8'h00, 8'h00, 8'h00,
              8'hAA, 8'h55, 8'hBB, 8'h66};
        expect_ev(12, EV_ERR, 64'h0);
        send_pkt(p, 1);
        check("quat_hold", {quat_x, quat_y, quat_z, quat_w},
              {16'h0100, 16'h8000, 16'h7FFF, 16'hC000});

        // Channel 2 with continuation bit: silently skipped, then a normal packet.
        p = '{8'h10, 8'h80, 8'h02, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00,
              8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        send_pkt(p, 1);
        p = '{8'h0E, 8'h00, 8'h03, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h10, 8'h00, 8'h20, 8'h00, 8'hF0, 8'hFF};
        expect_ev(13, EV_GYRO, {16'h0010, 16'h0020, 16'hFFF0, 16'h0000});
        send_pkt(p, 1);

        // pkt_start mid-gyro aborts with one error; the restarted packet parses.
        p = '{8'h0E, 8'h00, 8'h03, 8'h06, 8'h02, 8'h00, 8'h00, 8'h00,
              8'h11, 8'h11, 8'h22};
        send_pkt(p, 0);
        p = '{8'h0E, 8'h00, 8'h03, 8'h07, 8'h02, 8'h00, 8'h00, 8'h00,
              8'hFF, 8'h7F, 8'h00, 8'h80, 8'h05, 8'h00};
        expect_ev(-1, EV_ERR, 64'h0);
        expect_ev(13, EV_GYRO, {16'h7FFF, 16'h8000, 16'h0005, 16'h0000});
        send_pkt(p, 1);

        // Unknown report ID: rest of packet skipped, no error, no pulse.
        p = '{8'h0C, 8'h00, 8'h03, 8'h08, 8'hF1, 8'h05, 8'h00, 8'h00,
              8'h00, 8'h34, 8'h12, 8'h00};
        send_pkt(p, 1);

        // Length 300 exceeds MAX_LEN: error at header, then truncation error.
        p = '{8'h2C, 8'h01, 8'h03, 8'h09};
        expect_ev(3, EV_ERR, 64'h0);
        expect_ev(4, EV_ERR, 64'h0);
        send_pkt(p, 1);

        // Length exactly MAX_LEN is accepted.
        p = '{8'h00, 8'h01, 8'h03, 8'h0A, 8'h05, 8'h00, 8'h00, 8'h00,
              8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'hF1};
        for (int i = 0; i < 237; i++) p.push_back(8'h00);
        expect_ev(17, EV_QUAT, {16'h0011, 16'h0022, 16'h0033, 16'h0044});
        send_pkt(p, 1);

        // Header-only packet, then stray bytes and pkt_end while idle.
        p = '{8'h04, 8'h00, 8'h03, 8'h0B};
        send_pkt(p, 1);
        send_byte(8'h05);
        send_byte(8'h02);
        pkt_end = 1'b1;
        tick();
        pkt_end = 1'b0;
        tick();

        // Reset mid-report clears outputs; parsing resumes afterwards.
        p = '{8'h0E, 8'h00, 8'h03, 8'h0C, 8'h02, 8'h00, 8'h00, 8'h00, 8'h55};
        send_pkt(p, 0);
        rst = 1'b1;
        tick();
        tick();
        check("post_rst_outs", {quat_x, quat_y, quat_z, quat_w, gyro_x, gyro_y, gyro_z},
              '0);
        rst = 1'b0;
        tick();
        p = '{8'h0E, 8'h00, 8'h03, 8'h0D, 8'h02, 8'h22, 8'h03, 8'h00,
              8'h00, 8'h02, 8'h00, 8'hFE, 8'h00, 8'h00};
        expect_ev(13, EV_GYRO, {16'h0200, 16'hFE00, 16'h0000, 16'h0000});
        send_pkt(p, 1);

        repeat (5) tick();
        check("sb_drained", {32'(sb.size()), 32'(pend.size())}, '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
